// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path (and the planned receiver):
// parity mode codes, one-hot FSM state encoding and the legal character widths.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int ST_W = 6;
  localparam logic [ST_W-1:0] ST_IDLE   = 6'b000001;
  localparam logic [ST_W-1:0] ST_START  = 6'b000010;
  localparam logic [ST_W-1:0] ST_DATA   = 6'b000100;
  localparam logic [ST_W-1:0] ST_PARITY = 6'b001000;
  localparam logic [ST_W-1:0] ST_STOP1  = 6'b010000;
  localparam logic [ST_W-1:0] ST_STOP2  = 6'b100000;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;

  // Mode 2'b11 is reserved and behaves as "no parity".
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..div and pulses tick on the last clock of each
// bit. restart pins the count at zero so the first bit after it is full length.
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == div);

  // Wrap on the tick, hold at zero while restart is asserted.
  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (restart || tick) cnt_d = '0;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter with build-time character width and run-time divisor,
// parity and stop-bit count. A one-entry holding buffer behind a valid/ready
// port lets the next character start right after the previous stop bit.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int DIV_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_BITS-1:0] s_data,
  input  logic [DIV_W-1:0]     cfg_div,
  input  logic [1:0]           cfg_parity,
  input  logic                 cfg_stop2,
  output logic                 tx,
  output logic                 tx_active,
  output logic                 busy
);

  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_width
    $error("uart_tx_frame: DATA_BITS must be within 5..9");
  end

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  logic [ST_W-1:0]      state_q, state_d;
  logic                 buf_full_q, buf_full_d;
  logic [DATA_BITS-1:0] buf_data_q, buf_data_d;
  logic [DIV_W-1:0]     buf_div_q, buf_div_d;
  logic [1:0]           buf_par_q, buf_par_d;
  logic                 buf_stop2_q, buf_stop2_d;
  logic [DATA_BITS-1:0] sh_data_q, sh_data_d;
  logic [DIV_W-1:0]     sh_div_q, sh_div_d;
  logic                 par_en_q, par_en_d;
  logic                 par_bit_q, par_bit_d;
  logic                 stop2_q, stop2_d;
  logic [CNT_W-1:0]     bitcnt_q, bitcnt_d;
  logic                 tx_q, tx_d;
  logic                 tx_active_q, tx_active_d;
  logic                 busy_q, busy_d;

  logic baud_restart, baud_tick, bit_tick;
  logic accept, frame_end, load_shift;

  // Counter is held at zero in IDLE so START always gets a full bit period.
  assign baud_restart = (state_q == ST_IDLE);
  assign bit_tick     = baud_tick && (state_q != ST_IDLE);

  uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (baud_restart),
    .div     (sh_div_q),
    .tick    (baud_tick)
  );

  assign accept     = s_valid && !buf_full_q;
  assign frame_end  = bit_tick && (((state_q == ST_STOP1) && !stop2_q) || (state_q == ST_STOP2));
  assign load_shift = buf_full_q && ((state_q == ST_IDLE) || frame_end);

  assign s_ready   = ~buf_full_q;
  assign tx        = tx_q;
  assign tx_active = tx_active_q;
  assign busy      = busy_q;

  // State register and control flags; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      buf_full_q  <= 1'b0;
      bitcnt_q    <= '0;
      tx_q        <= 1'b1;
      tx_active_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_full_q  <= buf_full_d;
      bitcnt_q    <= bitcnt_d;
      tx_q        <= tx_d;
      tx_active_q <= tx_active_d;
      busy_q      <= busy_d;
    end
  end

  // Character and configuration snapshots; only meaningful while flagged valid.
  always_ff @(posedge clk) begin
    buf_data_q  <= buf_data_d;
    buf_div_q   <= buf_div_d;
    buf_par_q   <= buf_par_d;
    buf_stop2_q <= buf_stop2_d;
    sh_data_q   <= sh_data_d;
    sh_div_q    <= sh_div_d;
    par_en_q    <= par_en_d;
    par_bit_q   <= par_bit_d;
    stop2_q     <= stop2_d;
  end

  // Frame sequencing; a full buffer at frame end chains straight into START.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (buf_full_q) state_d = ST_START;
      ST_START:  if (bit_tick) state_d = ST_DATA;
      ST_DATA:   if (bit_tick && (bitcnt_q == LAST_BIT)) state_d = par_en_q ? ST_PARITY : ST_STOP1;
      ST_PARITY: if (bit_tick) state_d = ST_STOP1;
      ST_STOP1:  if (bit_tick) state_d = stop2_q ? ST_STOP2 : (buf_full_q ? ST_START : ST_IDLE);
      ST_STOP2:  if (bit_tick) state_d = buf_full_q ? ST_START : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Holding buffer fill/drain and shifter load/shift.
  always_comb begin
    buf_full_d  = buf_full_q;
    buf_data_d  = buf_data_q;
    buf_div_d   = buf_div_q;
    buf_par_d   = buf_par_q;
    buf_stop2_d = buf_stop2_q;
    sh_data_d   = sh_data_q;
    sh_div_d    = sh_div_q;
    par_en_d    = par_en_q;
    par_bit_d   = par_bit_q;
    stop2_d     = stop2_q;
    bitcnt_d    = bitcnt_q;
    if (load_shift) begin
      buf_full_d = 1'b0;
      sh_data_d  = buf_data_q;
      sh_div_d   = buf_div_q;
      par_en_d   = parity_enabled(buf_par_q);
      par_bit_d  = (buf_par_q == PAR_ODD) ? ~^buf_data_q : ^buf_data_q;
      stop2_d    = buf_stop2_q;
      bitcnt_d   = '0;
    end else if ((state_q == ST_DATA) && bit_tick) begin
      sh_data_d = sh_data_q >> 1;
      bitcnt_d  = bitcnt_q + CNT_W'(1);
    end
    if (accept) begin
      buf_full_d  = 1'b1;
      buf_data_d  = s_data;
      buf_div_d   = cfg_div;
      buf_par_d   = cfg_parity;
      buf_stop2_d = cfg_stop2;
    end
  end

  // Registered line outputs, decoded from the state being entered.
  always_comb begin
    tx_d        = 1'b1;
    tx_active_d = 1'b0;
    case (state_d)
      ST_START:  begin tx_d = 1'b0;         tx_active_d = 1'b1; end
      ST_DATA:   begin tx_d = sh_data_d[0]; tx_active_d = 1'b1; end
      ST_PARITY: begin tx_d = par_bit_d;    tx_active_d = 1'b1; end
      default:   begin tx_d = 1'b1;         tx_active_d = 1'b0; end
    endcase
    busy_d = (state_d != ST_IDLE) || buf_full_d;
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: the driver queues each expected frame
// as it hands a character over; the monitor decodes tx/tx_active clock by clock.
module tb_uart_tx_frame;

  localparam int DB = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DB-1:0] s_data = '0;
  logic [DW-1:0] cfg_div = '0;
  logic [1:0]    cfg_parity = 2'b00;
  logic          cfg_stop2 = 1'b0;
  logic          tx, tx_active, busy;

  always #5 clk = ~clk;

  uart_tx_frame #(.DATA_BITS(DB), .DIV_W(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .cfg_div    (cfg_div),
    .cfg_parity (cfg_parity),
    .cfg_stop2  (cfg_stop2),
    .tx         (tx),
    .tx_active  (tx_active),
    .busy       (busy)
  );

  typedef struct {
    logic [DB-1:0] data;
    int            div;
    bit            has_par;
    bit            par_bit;
    bit            stop2;
    bit            contig;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  int   idle_clks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Walks one frame starting at the current negedge (start bit already seen).
  task automatic run_frame(input exp_t e);
    logic [12:0] bits;
    logic [12:0] act;
    int nb;
    bits = '0;
    act = '0;
    bits[0] = 1'b0; act[0] = 1'b1; nb = 1;
    for (int i = 0; i < DB; i++) begin bits[nb] = e.data[i]; act[nb] = 1'b1; nb++; end
    if (e.has_par) begin bits[nb] = e.par_bit; act[nb] = 1'b1; nb++; end
    bits[nb] = 1'b1; nb++;
    if (e.stop2) begin bits[nb] = 1'b1; nb++; end
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c <= e.div; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        chk($sformatf("frame_%02h_bit%0d_clk%0d", e.data, b, c),
            {30'd0, tx, tx_active}, {30'd0, bits[b], act[b]});
      end
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_start_bit", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          if (e.contig) chk($sformatf("gap_before_%02h", e.data), idle_clks, 0);
          run_frame(e);
          idle_clks = 0;
        end
      end else begin
        idle_clks++;
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Presents one character at a negedge and returns at the negedge after the accept edge.
  task automatic send(input logic [DB-1:0] d, input int div, input logic [1:0] par,
                      input logic st2, input bit has_par, input bit par_bit,
                      input bit contig, input bit push, output int waited);
    exp_t e;
    s_valid = 1'b1; s_data = d; cfg_div = DW'(div); cfg_parity = par; cfg_stop2 = st2;
    waited = 0;
    while (!s_ready && waited < 5000) begin @(negedge clk); waited++; end
    if (!s_ready) begin
      chk($sformatf("accept_timeout_%02h", d), s_ready, 1);
      s_valid = 1'b0;
      return;
    end
    e = '{d, div, has_par, par_bit, st2, contig};
    if (push) exp_q.push_back(e);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 5000) begin @(negedge clk); n++; end
    chk("idle_reached", busy, 0);
  endtask

  int w;

  initial begin : stim
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_tx_active", tx_active, 0);
    chk("rst_busy", busy, 0);
    chk("rst_s_ready", s_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // 0xA5, div 3, 8N1: tx goes low one clock after the accept edge.
    send(8'hA5, 3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, w);
    chk("lat_tx_still_idle", tx, 1);
    chk("lat_s_ready_low", s_ready, 0);
    chk("lat_busy", busy, 1);
    @(negedge clk);
    chk("lat_tx_start", tx, 0);
    wait_idle();

    // Parity: 0x07 even -> 1, 0x07 odd -> 0, 0x00 even -> 0, mode 11 -> none.
    send(8'h07, 3, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, w); wait_idle();
    send(8'h07, 3, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, w); wait_idle();
    send(8'h00, 2, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, w); wait_idle();
    send(8'h81, 1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, w); wait_idle();

    // Two stop bits, 1-clock bits: 11-clock frame, busy drops the clock after.
    send(8'hFF, 0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, w);
    repeat (11) @(negedge clk);
    chk("stop2_busy_last_bit", busy, 1);
    @(negedge clk);
    chk("stop2_busy_fall", busy, 0);
    wait_idle();

    // Back-to-back: frames must abut with zero idle clocks.
    send(8'h55, 3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, w);
    send(8'hAA, 3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, w);
    chk("b2b_second_waited", (w > 0), 1);
    send(8'h0F, 3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, w);
    chk("b2b_third_waited", (w > 0), 1);
    wait_idle();

    // Divisor change mid-frame only affects the next accepted character.
    send(8'h3C, 3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, w);
    repeat (12) @(negedge clk);
    cfg_div = DW'(7);
    wait_idle();
    send(8'hC3, 7, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, w);
    wait_idle();

    // Reset in the middle of a data bit, then a clean frame.
    mon_en = 1'b0;
    send(8'h5A, 3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, w);
    repeat (10) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_tx", tx, 1);
    chk("midrst_tx_active", tx_active, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_s_ready", s_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    send(8'h96, 1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, w);
    wait_idle();

    repeat (4) @(negedge clk);
    chk("all_frames_seen", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
